// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen
//
// Enumerates every 8-bit word with exactly k set bits (k = 0..8), one word
// per accepted handshake, in ascending numeric order.  One candidate word is
// tested per cycle; matching candidates are registered onto a valid/ready
// output stream.  The final word of a run carries out_last, and a one-cycle
// done pulse follows its handshake.
//
// Build option:
//   ONES_GEN_DESC_EN  when defined, the scan starts at 8'hFF and counts down,
//                     so words are emitted in descending order and the final
//                     word is the k low bits set.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      run request, sampled only while idle
//   ones_req   requested ones count k (legal 0..8)
//   out_data   current pattern
//   out_valid  out_data holds a pattern
//   out_ready  consumer accepts (handshake = out_valid & out_ready)
//   out_last   final pattern of the run, qualified by out_valid
//   busy       high while scanning and in the done cycle
//   done       one-cycle pulse after the last handshake
//   err        one-cycle pulse after a start with ones_req > 8

module ones_pattern_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ones_req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

`ifdef ONES_GEN_DESC_EN
  localparam logic [7:0] FIRST_CAND = 8'hFF;
`else
  localparam logic [7:0] FIRST_CAND = 8'h00;
`endif

  state_t     state_r;
  logic [7:0] cand_r;
  logic [3:0] k_r;
  // Set once the final pattern has been tested; stops the scan from wrapping.
  logic       exhausted_r;

  logic       slot_s;
  logic       match_s;
  logic       is_last_s;
  logic       hs_s;
  logic       fin_hs_s;
  logic [7:0] last_pat_s;
  logic [7:0] next_cand_s;

  // Number of set bits in an 8-bit word; 4 bits wide so that 8 fits.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'b000, v[i]};
    end
    return sum;
  endfunction

  // Final pattern of a run for ones count k: the k top bits set when scanning
  // upward, the k low bits set when scanning downward.  k = 0 gives 8'h00.
  function automatic logic [7:0] last_pattern(input logic [3:0] k);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
`ifdef ONES_GEN_DESC_EN
      p[i] = (4'(i) < k);
`else
      p[i] = (4'(i) >= (4'd8 - k));
`endif
    end
    return p;
  endfunction

  // Candidate following c in scan order.
  function automatic logic [7:0] scan_step(input logic [7:0] c);
`ifdef ONES_GEN_DESC_EN
    return c - 8'd1;
`else
    return c + 8'd1;
`endif
  endfunction

  // Per-cycle scan decisions derived from the current state and handshake.
  always_comb begin
    slot_s      = 1'b0;
    match_s     = 1'b0;
    is_last_s   = 1'b0;
    hs_s        = out_valid & out_ready;
    fin_hs_s    = 1'b0;
    last_pat_s  = last_pattern(k_r);
    next_cand_s = scan_step(cand_r);
    if (state_r == ST_SCAN) begin
      // A test slot exists whenever the output register is free or is being
      // drained this cycle, as long as the final pattern has not been tested.
      slot_s    = ~exhausted_r & (~out_valid | out_ready);
      match_s   = (popcount8(cand_r) == k_r);
      is_last_s = (cand_r == last_pat_s);
      fin_hs_s  = hs_s & out_last;
    end else begin
      slot_s    = 1'b0;
      match_s   = 1'b0;
      is_last_s = 1'b0;
      fin_hs_s  = 1'b0;
    end
  end

  // Control FSM, candidate scan and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cand_r      <= 8'h00;
      k_r         <= 4'd0;
      exhausted_r <= 1'b0;
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (ones_req > 4'd8) begin
              err <= 1'b1;
            end else begin
              k_r         <= ones_req;
              cand_r      <= FIRST_CAND;
              exhausted_r <= 1'b0;
              busy        <= 1'b1;
              state_r     <= ST_SCAN;
            end
          end
        end

        ST_SCAN: begin
          if (fin_hs_s) begin
            // The last word leaves this edge; nothing remains to test.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state_r   <= ST_DONE;
          end else if (slot_s) begin
            if (match_s) begin
              out_data  <= cand_r;
              out_valid <= 1'b1;
              out_last  <= is_last_s;
            end else if (hs_s) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
            // The final pattern always matches, so stopping here never
            // skips a word; the candidate is simply parked on it.
            if (is_last_s) begin
              exhausted_r <= 1'b1;
            end else begin
              cand_r <= next_cand_s;
            end
          end
        end

        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
